icmp_echo_filter: RTL and testbench
===================================

ICMP_ECHO_FILTER -- requirements
Module: icmp_echo_filter

Interface
REQ-001 Parameter LOCAL_IP, default 32'h0100000A: destination IPv4 address (10.0.0.1) in stream byte-lane order, byte 0 in [7:0].
REQ-002 Parameter MATCH_DST, default 1: 1 = also require the destination address to equal LOCAL_IP; 0 = ignore the destination address.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stream_in_data/empty/valid/startofpacket/endofpacket  input  32/2/1/1/1  upstream raw IPv4 packet stream from the TUN source.
REQ-006 stream_in_ready  output  1  upstream backpressure.
REQ-007 stream_out_data/empty/valid/startofpacket/endofpacket  output  32/2/1/1/1  filtered stream to the echo responder; all registered.
REQ-008 stream_out_ready  input  1  downstream backpressure.

Function
REQ-009 The block SHALL forward unmodified only IPv4 ICMP echo requests: word0[7:0]==8'h45, word2[15:8]==8'h01, word5[7:0]==8'h08, word5[15:8]==8'h00, and word4==LOCAL_IP when MATCH_DST=1. It SHALL consume and discard every other packet.
REQ-010 FSM states: IDLE, HEAD, REPLAY, PASS, DROP.
REQ-011 IDLE: stream_in_ready=1. An accepted beat with SOP stores word0 in head buffer [0] and moves to HEAD. Non-SOP beats SHALL be accepted and discarded.
REQ-012 HEAD: stream_in_ready=1. Words 1..5 go into the 6x32 head buffer. A 3-bit index counts the stored words, and the EMPTY value of the last beat is saved.
REQ-013 On acceptance of word5, the next state SHALL be REPLAY if the match passes, otherwise DROP. If word5 carried EOP, the next state SHALL instead be REPLAY (pass) or IDLE (drop).
REQ-014 If EOP arrives before word5 (packet shorter than 6 words), the packet SHALL be dropped and the FSM SHALL return to IDLE.
REQ-015 If SOP arrives in HEAD, the partial packet SHALL be dropped and collection SHALL restart with that beat as word0.
REQ-016 REPLAY: stream_in_ready=0. Buffered words 0..5 are emitted in order.
  - stream_out_startofpacket=1 on word 0 only.
  - EOP and the saved EMPTY are asserted on word 5 if the packet ended there; the FSM then goes to IDLE.
  - Otherwise the FSM goes to PASS after word 5 is accepted.
REQ-017 PASS: stream_in_ready = !stream_out_valid || stream_out_ready. Each accepted input beat is registered to the output with data and empty unchanged. The FSM returns to IDLE when the EOP beat is accepted downstream.
REQ-018 DROP: stream_in_ready=1. Beats are discarded; accepting EOP returns the FSM to IDLE.
REQ-019 The output SHALL hold data, empty, SOP and EOP stable while stream_out_valid=1 and stream_out_ready=0.
REQ-020 Latency: the first output word SHALL be valid on the cycle after word5 is accepted. Throughput in PASS SHALL be one word per cycle when stream_out_ready=1.
REQ-021 stream_out_empty SHALL be 0 on every non-EOP beat.

Reset
REQ-022 While reset=1: FSM=IDLE, buffer index=0, stream_out_valid/startofpacket/endofpacket=0, stream_out_empty=0, stream_out_data=0, stream_in_ready=0.
REQ-023 Reset mid-packet SHALL abandon that packet silently, with no counter update. The first SOP after reset SHALL be processed normally.

Configuration
REQ-024 Macro ICMP_FILTER_STATS_EN controls the statistics outputs.
  - Defined: adds outputs pass_count[15:0] and drop_count[15:0], both reset to 0 and saturating at 16'hFFFF. pass_count increments on a match decision; drop_count increments on every dropped packet, including short and SOP-restarted packets.
  - Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Structure
REQ-025 Package icmp_pkg SHALL hold:
  - the FSM state enum typedef;
  - word indices WORD_VER=0, WORD_PROTO=2, WORD_DST=4, WORD_ICMP=5;
  - constants IPV4_VER_IHL=8'h45, PROTO_ICMP=8'h01, ICMP_ECHO_REQ=8'h08, ICMP_ECHO_REPLY=8'h00.
REQ-026 One sub-module, icmp_hdr_check, SHALL contain the combinational match over the 6-word header. The FSM, head buffer and output register stay in icmp_echo_filter.

Verification
REQ-027 21-word echo request: word0=32'h54000045, word2 proto=8'h01, word4=32'h0100000A, word5=32'hF7FF0008, empty=0 on the last word -> 21 identical words out, SOP on word 0, EOP on word 20; pass_count=1.
REQ-028 Same packet with word2 proto=8'h06 (TCP) -> no output; stream_in_ready stays 1 throughout; drop_count=1.
REQ-029 Echo reply (word5[7:0]=8'h00), then a 4-word packet -> no output; drop_count=2.
REQ-030 Stream a valid packet with stream_out_ready toggling 1,0,1,0 -> all words delivered in order, none duplicated; data held stable during each stall.
REQ-031 Exactly 6-word matching packet with empty=2'd2 -> 6 words out; EOP and empty=2 on word 5; FSM back in IDLE the following cycle.
REQ-032 Assert reset for 1 cycle during PASS -> stream_out_valid=0 on the next cycle; the next valid packet is forwarded intact; counters read 0 (STATS_EN defined).

Source files
------------

// File: rtl/icmp_pkg.sv
// Shared types and constants for the ICMP echo-request filter.
// No logic. Used by icmp_echo_filter and icmp_hdr_check.
// The header word indices count from word 0, the first 32-bit beat of the packet.
package icmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_REPLAY,
        ST_PASS,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  empty;
        logic        sop;
        logic        eop;
    } beat_t;

    localparam logic [2:0] WORD_VER   = 3'd0;
    localparam logic [2:0] WORD_PROTO = 3'd2;
    localparam logic [2:0] WORD_DST   = 3'd4;
    localparam logic [2:0] WORD_ICMP  = 3'd5;

    localparam logic [7:0] IPV4_VER_IHL    = 8'h45;
    localparam logic [7:0] PROTO_ICMP      = 8'h01;
    localparam logic [7:0] ICMP_ECHO_REQ   = 8'h08;
    localparam logic [7:0] ICMP_ECHO_REPLY = 8'h00;
    localparam logic [7:0] ICMP_CODE_ECHO  = 8'h00;

endpackage

// File: rtl/icmp_hdr_check.sv
// Decides whether a 6-word IPv4 header is an ICMP echo request for this host.
// Latency: purely combinational, no clock.
// Backpressure: none; the caller samples the match when word 5 is accepted.
module icmp_hdr_check
    import icmp_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP  = 32'h0100000A,
    parameter bit          MATCH_DST = 1'b1
) (
    input  logic [5:0][31:0] hdr,
    output logic             match
);

    logic ver_ok;
    logic proto_ok;
    logic icmp_ok;
    logic dst_ok;

    always_comb begin
        ver_ok   = (hdr[WORD_VER][7:0]    == IPV4_VER_IHL);
        proto_ok = (hdr[WORD_PROTO][15:8] == PROTO_ICMP);
        icmp_ok  = (hdr[WORD_ICMP][7:0]   == ICMP_ECHO_REQ) &&
                   (hdr[WORD_ICMP][15:8]  == ICMP_CODE_ECHO);
        dst_ok   = !MATCH_DST || (hdr[WORD_DST] == LOCAL_IP);
        match    = ver_ok && proto_ok && icmp_ok && dst_ok;
    end

    // Header fields that play no part in the decision.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{hdr[1], hdr[3], hdr[WORD_VER][31:8],
                               hdr[WORD_PROTO][31:16], hdr[WORD_PROTO][7:0],
                               hdr[WORD_ICMP][31:16]};

endmodule

// File: rtl/icmp_echo_filter.sv
// Forwards only IPv4 ICMP echo requests for LOCAL_IP; drops everything else. Optional stats: ICMP_FILTER_STATS_EN.
// Latency: first output word one cycle after header word 5 is accepted; then 1 word/cycle.
// Backpressure: header collected at full rate, replay stalls input, pass-through follows stream_out_ready.
module icmp_echo_filter
    import icmp_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP  = 32'h0100000A,
    parameter bit          MATCH_DST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] stream_in_data,
    input  logic [1:0]  stream_in_empty,
    input  logic        stream_in_valid,
    input  logic        stream_in_startofpacket,
    input  logic        stream_in_endofpacket,
    output logic        stream_in_ready,
    output logic [31:0] stream_out_data,
    output logic [1:0]  stream_out_empty,
    output logic        stream_out_valid,
    output logic        stream_out_startofpacket,
    output logic        stream_out_endofpacket,
    input  logic        stream_out_ready
`ifdef ICMP_FILTER_STATS_EN
    ,
    output logic [15:0] pass_count,
    output logic [15:0] drop_count
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      head_buf [6];
    logic [2:0]       idx;
    logic [1:0]       saved_empty;
    logic             pkt_ended;
    beat_t            out_q;
    logic             out_vld;
    logic [5:0][31:0] hdr_words;
    logic             hdr_match;
    logic             in_fire;
    logic             out_fire;
    logic             out_free;
    logic             in_sop;
    logic             in_eop;

    assign in_sop   = stream_in_startofpacket;
    assign in_eop   = stream_in_endofpacket;
    assign in_fire  = stream_in_valid && stream_in_ready;
    assign out_fire = out_vld && stream_out_ready;
    assign out_free = !out_vld || stream_out_ready;

    // Word 5 is checked straight off the input so the decision lands on its acceptance edge.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            hdr_words[i] = head_buf[i];
        end
        hdr_words[5] = stream_in_data;
    end

    icmp_hdr_check #(
        .LOCAL_IP  (LOCAL_IP),
        .MATCH_DST (MATCH_DST)
    ) u_hdr_check (
        .hdr   (hdr_words),
        .match (hdr_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_fire && in_sop && !in_eop) begin
                    state_nxt = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (in_fire) begin
                    if (in_sop) begin
                        state_nxt = in_eop ? ST_IDLE : ST_HEAD;
                    end else if (idx == 3'd5) begin
                        if (hdr_match) begin
                            state_nxt = ST_REPLAY;
                        end else begin
                            state_nxt = in_eop ? ST_IDLE : ST_DROP;
                        end
                    end else if (in_eop) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_REPLAY: begin
                if (out_fire && idx == 3'd6) begin
                    state_nxt = pkt_ended ? ST_IDLE : ST_PASS;
                end
            end
            ST_PASS: begin
                if (out_fire && out_q.eop) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (in_fire && in_eop) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // In PASS, once the EOP beat sits in the output register, the next
    // packet's SOP must wait until the FSM is back in IDLE.
    always_comb begin
        stream_in_ready = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE, ST_HEAD, ST_DROP: stream_in_ready = 1'b1;
                ST_PASS:                   stream_in_ready = out_free && !(out_vld && out_q.eop);
                default:                   stream_in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire && in_sop && (state == ST_IDLE || state == ST_HEAD)) begin
            head_buf[0] <= stream_in_data;
        end else if (in_fire && state == ST_HEAD) begin
            head_buf[idx] <= stream_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= 3'd0;
            saved_empty <= 2'd0;
            pkt_ended   <= 1'b0;
            out_q       <= '0;
            out_vld     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire && in_sop && !in_eop) begin
                        idx <= 3'd1;
                    end
                end
                ST_HEAD: begin
                    if (in_fire) begin
                        saved_empty <= stream_in_empty;
                        if (in_sop) begin
                            idx <= in_eop ? 3'd0 : 3'd1;
                        end else if (idx == 3'd5) begin
                            pkt_ended <= in_eop;
                            if (hdr_match) begin
                                out_q   <= '{data: head_buf[0], empty: 2'd0, sop: 1'b1, eop: 1'b0};
                                out_vld <= 1'b1;
                                idx     <= 3'd1;
                            end else begin
                                idx <= 3'd0;
                            end
                        end else if (in_eop) begin
                            idx <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_REPLAY: begin
                    if (out_fire) begin
                        if (idx == 3'd6) begin
                            out_vld <= 1'b0;
                            idx     <= 3'd0;
                        end else begin
                            out_q.data  <= head_buf[idx];
                            out_q.sop   <= 1'b0;
                            out_q.eop   <= (idx == 3'd5) && pkt_ended;
                            out_q.empty <= ((idx == 3'd5) && pkt_ended) ? saved_empty : 2'd0;
                            idx         <= idx + 3'd1;
                        end
                    end
                end
                ST_PASS: begin
                    if (in_fire) begin
                        out_q   <= '{data: stream_in_data,
                                     empty: in_eop ? stream_in_empty : 2'd0,
                                     sop: 1'b0, eop: in_eop};
                        out_vld <= 1'b1;
                    end else if (out_fire) begin
                        out_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stream_out_data          = out_q.data;
    assign stream_out_empty         = out_q.empty;
    assign stream_out_startofpacket = out_q.sop;
    assign stream_out_endofpacket   = out_q.eop;
    assign stream_out_valid         = out_vld;

`ifdef ICMP_FILTER_STATS_EN
    logic pass_evt;
    logic drop_evt;

    // A SOP seen mid-header costs the partial packet one drop.
    always_comb begin
        pass_evt = (state == ST_HEAD) && in_fire && !in_sop && (idx == 3'd5) && hdr_match;
        drop_evt = ((state == ST_HEAD) && in_fire &&
                    (in_sop || (idx == 3'd5 && !hdr_match) || (idx != 3'd5 && in_eop))) ||
                   ((state == ST_IDLE) && in_fire && in_sop && in_eop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pass_count <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            if (pass_evt && pass_count != 16'hFFFF) begin
                pass_count <= pass_count + 16'd1;
            end
            if (drop_evt && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icmp_echo_filter.sv
// Directed bench for icmp_echo_filter: packet table plus reset, restart and back-to-back sequences.
`timescale 1ns/1ps
module tb_icmp_echo_filter;

    localparam logic [31:0] LOCAL_IP = 32'h0100000A;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_empty;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_empty;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready;
`ifdef ICMP_FILTER_STATS_EN
    logic [15:0] pass_count;
    logic [15:0] drop_count;
`endif

    icmp_echo_filter #(.LOCAL_IP(LOCAL_IP), .MATCH_DST(1'b1)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .stream_in_data           (in_data),
        .stream_in_empty          (in_empty),
        .stream_in_valid          (in_valid),
        .stream_in_startofpacket  (in_sop),
        .stream_in_endofpacket    (in_eop),
        .stream_in_ready          (in_ready),
        .stream_out_data          (out_data),
        .stream_out_empty         (out_empty),
        .stream_out_valid         (out_valid),
        .stream_out_startofpacket (out_sop),
        .stream_out_endofpacket   (out_eop),
        .stream_out_ready         (out_ready)
`ifdef ICMP_FILTER_STATS_EN
        ,
        .pass_count               (pass_count),
        .drop_count               (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit [63:0]   nm;
        logic [7:0]  ver;
        logic [7:0]  proto;
        logic [7:0]  itype;
        logic [31:0] dst;
        int          nwords;
        logic [1:0]  last_empty;
        bit          tog;
        bit          exp_pass;
        int          exp_pc;
        int          exp_dc;
        int          id;
    } tc_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  e;
        logic        s;
        logic        p;
        int          c;
    } obeat_t;

    obeat_t oq[$];
    bit     ready_toggle;

    function automatic tc_t mk(bit [63:0] nm, logic [7:0] ver, logic [7:0] proto, logic [7:0] itype,
                               logic [31:0] dst, int n, logic [1:0] le, bit tog, bit ep,
                               int pc, int dc, int id);
        tc_t t;
        t.nm = nm; t.ver = ver; t.proto = proto; t.itype = itype; t.dst = dst;
        t.nwords = n; t.last_empty = le; t.tog = tog; t.exp_pass = ep;
        t.exp_pc = pc; t.exp_dc = dc; t.id = id;
        return t;
    endfunction

    function automatic logic [31:0] pkt_word(tc_t t, int k);
        case (k)
            0:       return {24'h540000, t.ver};
            1:       return 32'h00001C46;
            2:       return {16'hB1E6, t.proto, 8'h40};
            3:       return 32'h0200000A;
            4:       return t.dst;
            5:       return {16'hF7FF, 8'h00, t.itype};
            default: return {8'hA5, 8'(t.id), 16'(k)};
        endcase
    endfunction

    // Output monitor: samples 1 ns before each rising edge.
    initial begin
        logic        stall;
        logic [35:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_stable", {out_valid, out_data, out_empty, out_sop, out_eop}, {1'b1, held});
                end
                if (out_valid && out_ready) begin
                    oq.push_back('{d: out_data, e: out_empty, s: out_sop, p: out_eop, c: cyc});
                end
                stall = out_valid && !out_ready;
                held  = {out_data, out_empty, out_sop, out_eop};
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = ready_toggle ? ~out_ready : 1'b1;
        end
    end

    // Sends words first..last of packet t; call just after a falling edge.
    task automatic send_pkt(input tc_t t, input int first, input int last,
                            output bit waited, output int w5cyc);
        waited = 1'b0;
        w5cyc  = -1;
        for (int k = first; k <= last; k++) begin
            bit acc;
            int budget;
            in_data  = pkt_word(t, k);
            in_sop   = (k == 0);
            in_eop   = (k == t.nwords - 1);
            in_empty = (k == t.nwords - 1) ? t.last_empty : 2'd0;
            in_valid = 1'b1;
            acc      = 1'b0;
            budget   = 0;
            while (!acc && budget < 200) begin
                #4;
                acc = in_ready;
                if (!acc) waited = 1'b1;
                if (acc && k == 5) w5cyc = cyc;
                @(negedge clk);
                budget++;
            end
            if (!acc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %0s_accept_timeout: word %0d never accepted", t.nm, k);
            end
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = 2'd0;
    endtask

    task automatic check_pkt(input tc_t t, input int base);
        for (int i = 0; i < t.nwords && base + i < oq.size(); i++) begin
            logic [1:0] ee;
            ee = (i == t.nwords - 1) ? t.last_empty : 2'd0;
            chk($sformatf("%0s_beat%0d", t.nm, i),
                {oq[base+i].d, oq[base+i].e, oq[base+i].s, oq[base+i].p},
                {pkt_word(t, i), ee, i == 0, i == t.nwords - 1});
        end
    endtask

    task automatic check_stats(input string nm, input int pc, input int dc);
`ifdef ICMP_FILTER_STATS_EN
        chk({nm, "_pass_count"}, pass_count, pc);
        chk({nm, "_drop_count"}, drop_count, dc);
`endif
    endtask

    task automatic run_case(input tc_t t);
        bit waited;
        int w5;
        ready_toggle = t.tog;
        oq.delete();
        send_pkt(t, 0, t.nwords - 1, waited, w5);
        repeat (40) @(negedge clk);
        ready_toggle = 1'b0;
        if (t.exp_pass) begin
            chk($sformatf("%0s_nbeats", t.nm), oq.size(), t.nwords);
            check_pkt(t, 0);
            if (!t.tog && oq.size() > 0) begin
                chk($sformatf("%0s_latency", t.nm), oq[0].c, w5 + 1);
                for (int i = 1; i < oq.size(); i++) begin
                    if (i != 6) chk($sformatf("%0s_rate%0d", t.nm, i), oq[i].c - oq[i-1].c, 1);
                end
            end
        end else begin
            chk($sformatf("%0s_nbeats", t.nm), oq.size(), 0);
            chk($sformatf("%0s_in_ready_stall", t.nm), waited, 0);
        end
        check_stats(string'(t.nm), t.exp_pc, t.exp_dc);
    endtask

    tc_t tcs[9];

    initial begin
        bit  waited;
        int  w5;
        tc_t e7, six, e21, e8;

        reset        = 1'b1;
        in_valid     = 1'b1;
        in_data      = 32'hDEADBEEF;
        in_sop       = 1'b1;
        in_eop       = 1'b0;
        in_empty     = 2'd3;
        ready_toggle = 1'b0;

        tcs[0] = mk("echo21",  8'h45, 8'h01, 8'h08, LOCAL_IP,     21, 2'd0, 1'b0, 1'b1, 1, 0, 1);
        tcs[1] = mk("tcp",     8'h45, 8'h06, 8'h08, LOCAL_IP,     21, 2'd0, 1'b0, 1'b0, 1, 1, 2);
        tcs[2] = mk("reply",   8'h45, 8'h01, 8'h00, LOCAL_IP,     10, 2'd0, 1'b0, 1'b0, 1, 2, 3);
        tcs[3] = mk("short4",  8'h45, 8'h01, 8'h08, LOCAL_IP,      4, 2'd1, 1'b0, 1'b0, 1, 3, 4);
        tcs[4] = mk("toggle",  8'h45, 8'h01, 8'h08, LOCAL_IP,      9, 2'd1, 1'b1, 1'b1, 2, 3, 5);
        tcs[5] = mk("six",     8'h45, 8'h01, 8'h08, LOCAL_IP,      6, 2'd2, 1'b0, 1'b1, 3, 3, 6);
        tcs[6] = mk("dstmiss", 8'h45, 8'h01, 8'h08, 32'h0200000A,  8, 2'd0, 1'b0, 1'b0, 3, 4, 7);
        tcs[7] = mk("verbad",  8'h46, 8'h01, 8'h08, LOCAL_IP,      8, 2'd0, 1'b0, 1'b0, 3, 5, 8);
        tcs[8] = mk("tail_e3", 8'h45, 8'h01, 8'h08, LOCAL_IP,      8, 2'd3, 1'b0, 1'b1, 4, 5, 9);

        // Reset state, with a live SOP beat presented upstream.
        repeat (2) @(negedge clk);
        #4;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sop_eop", {out_sop, out_eop}, 0);
        chk("rst_out_data_empty", {out_data, out_empty}, 0);
        chk("rst_in_ready", in_ready, 0);
        check_stats("rst", 0, 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_empty = 2'd0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_case(tcs[i]);
        end

        // Stray non-SOP beats in IDLE, then a SOP restart in mid-header.
        e7 = mk("echo7", 8'h45, 8'h01, 8'h08, LOCAL_IP, 7, 2'd1, 1'b0, 1'b1, 5, 6, 10);
        oq.delete();
        in_valid = 1'b1;
        in_data  = 32'h11223344;
        in_eop   = 1'b1;
        @(negedge clk);
        in_eop   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        send_pkt(e7, 0, 2, waited, w5);
        send_pkt(e7, 0, 6, waited, w5);
        repeat (30) @(negedge clk);
        chk("restart_nbeats", oq.size(), 7);
        check_pkt(e7, 0);
        check_stats("restart", 5, 6);

        // Two 6-word packets back to back: FSM must be in IDLE right after the first EOP.
        six = tcs[5];
        oq.delete();
        send_pkt(six, 0, 5, waited, w5);
        send_pkt(six, 0, 5, waited, w5);
        repeat (30) @(negedge clk);
        chk("b2b_nbeats", oq.size(), 12);
        check_pkt(six, 0);
        check_pkt(six, 6);
        check_stats("b2b", 7, 6);

        // One-cycle reset while streaming through PASS, then the old tail, then a fresh packet.
        e21 = tcs[0];
        e8  = mk("echo8", 8'h45, 8'h01, 8'h08, LOCAL_IP, 8, 2'd0, 1'b0, 1'b1, 1, 0, 11);
        send_pkt(e21, 0, 8, waited, w5);
        reset = 1'b1;
        #4;
        chk("pass_rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #4;
        chk("pass_rst_out_valid", out_valid, 0);
        check_stats("pass_rst", 0, 0);
        @(negedge clk);
        send_pkt(e21, 9, 20, waited, w5);
        repeat (5) @(negedge clk);
        oq.delete();
        send_pkt(e8, 0, 7, waited, w5);
        repeat (30) @(negedge clk);
        chk("post_rst_nbeats", oq.size(), 8);
        check_pkt(e8, 0);
        check_stats("post_rst", 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

endmodule
